mini_core_lsu_pipe: RTL and testbench

//  Parametrised load/store access stage between Q103H (execute) and Q104H (write-back).
//  - Aligns byte/half/word requests: byte enables, write-data lane replication, misalign detect.
//  - Tracks up to OUTSTANDING in-order loads in a metadata queue.
//  - Sign/zero-extends returned load data and stalls the core on back-pressure or queue full.

---
 rtl/mini_core_lsu_pipe_pkg.sv | 50 +++++
 rtl/mini_core_lsu_pipe_if.sv | 52 +++++
 rtl/mini_core_lsu_meta_fifo.sv | 71 +++++++
 rtl/mini_core_lsu_pipe.sv | 123 ++++++++++++
 tb/tb_mini_core_lsu_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mini_core_lsu_pipe_pkg.sv
// Shared types and helpers for the load/store access stage (Q103H -> Q104H).
// Covers access size, queued load metadata, byte-lane alignment and load extension.
package mini_core_lsu_pipe_pkg;

   typedef enum logic [1:0] {
      LSU_BYTE = 2'd0,
      LSU_HALF = 2'd1,
      LSU_WORD = 2'd2
   } t_lsu_size;

   typedef struct packed {
      logic [1:0] offset;
      t_lsu_size  size;
      logic       is_unsigned;
   } t_lsu_meta;

   function automatic logic lsu_misaligned(input t_lsu_size size, input logic [1:0] off);
      logic mis;
      case (size)
         LSU_HALF: mis = off[0];
         LSU_WORD: mis = (off != 2'b00);
         default:  mis = 1'b0;
      endcase
      return mis;
   endfunction

   function automatic logic [3:0] lsu_byte_en(input t_lsu_size size, input logic [1:0] off);
      logic [3:0] be;
      case (size)
         LSU_BYTE: be = 4'b0001 << off;
         LSU_HALF: be = 4'b0011 << off;
         default:  be = 4'b1111;
      endcase
      return be;
   endfunction

   // Raw word is lane-shifted down to bit 0 before extension.
   function automatic logic [31:0] lsu_extend(input logic [31:0] raw, input t_lsu_meta meta);
      logic [31:0] sh;
      logic [31:0] res;
      sh = raw >> {meta.offset, 3'b000};
      case (meta.size)
         LSU_BYTE: res = meta.is_unsigned ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         LSU_HALF: res = meta.is_unsigned ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default:  res = raw;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mini_core_lsu_pipe_if.sv
// Bundle of core-side request, data-memory request/response and Q104H result signals.
// The LSU sits on the slave modport; the core/memory side uses master.
interface mini_core_lsu_pipe_if #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 3
) ();
   import mini_core_lsu_pipe_pkg::*;

   logic              req_valid;
   logic              req_rd;
   logic              req_wr;
   t_lsu_size         req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] alu_out;
   logic [31:0]       wr_data;
   logic [31:0]       pc_plus4;
   logic              ready_q104h;
   logic              dmem_req_ready;
   logic              dmem_rsp_valid;
   logic [31:0]       dmem_rsp_data;

   logic [31:0]       dmem_wr_data;
   logic [ADDR_W-1:0] dmem_address;
   logic              dmem_wr_en;
   logic              dmem_rd_en;
   logic [3:0]        dmem_byte_en;
   logic              stall;
   logic              misalign;
   logic              load_valid;
   logic [31:0]       load_data;
   logic              rsp_orphan;
   logic [CNT_W-1:0]  outstanding_cnt;
   logic [31:0]       pc_plus4_q104h;
   logic [ADDR_W-1:0] alu_out_q104h;

   modport slave (
      input  req_valid, req_rd, req_wr, req_size, req_unsigned, alu_out, wr_data,
             pc_plus4, ready_q104h, dmem_req_ready, dmem_rsp_valid, dmem_rsp_data,
      output dmem_wr_data, dmem_address, dmem_wr_en, dmem_rd_en, dmem_byte_en,
             stall, misalign, load_valid, load_data, rsp_orphan, outstanding_cnt,
             pc_plus4_q104h, alu_out_q104h
   );

   modport master (
      output req_valid, req_rd, req_wr, req_size, req_unsigned, alu_out, wr_data,
             pc_plus4, ready_q104h, dmem_req_ready, dmem_rsp_valid, dmem_rsp_data,
      input  dmem_wr_data, dmem_address, dmem_wr_en, dmem_rd_en, dmem_byte_en,
             stall, misalign, load_valid, load_data, rsp_orphan, outstanding_cnt,
             pc_plus4_q104h, alu_out_q104h
   );

endinterface

// File: rtl/mini_core_lsu_meta_fifo.sv
// In-order metadata queue for loads accepted by memory but not yet answered.
// Push while full is accepted only when a pop happens in the same cycle.
module mini_core_lsu_meta_fifo
   import mini_core_lsu_pipe_pkg::*;
#(
   parameter int  DEPTH     = 4,
   parameter type T_PAYLOAD = t_lsu_meta
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  T_PAYLOAD                   push_data_i,
   input  logic                       pop_i,
   output T_PAYLOAD                   pop_data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   T_PAYLOAD         mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty_o    = (count_q == '0);
   assign full_o     = (count_q == CNT_W'(DEPTH));
   assign count_o    = count_q;
   assign pop_data_o = mem_q[rd_ptr_q];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset: entries are only read behind the count.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/mini_core_lsu_pipe.sv
// Load/store access stage between Q103H and Q104H: aligns requests, tracks in-flight
// loads in order, extends returned data and stalls the core on back-pressure.
module mini_core_lsu_pipe
   import mini_core_lsu_pipe_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int OUTSTANDING = 4,
   parameter bit REG_RSP     = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   mini_core_lsu_pipe_if.slave lsu_bus
);
   localparam int CNT_W = $clog2(OUTSTANDING + 1);

   logic [1:0]        off;
   logic              op_vld;
   logic              misalign;
   logic              issue;
   logic              accept;
   logic              push;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_cnt;
   t_lsu_meta         push_meta;
   t_lsu_meta         head_meta;
   logic [31:0]       ext_data;
   logic [31:0]       pc_plus4_q;
   logic [ADDR_W-1:0] alu_out_q;

   assign off      = lsu_bus.alu_out[1:0];
   assign op_vld   = lsu_bus.req_valid & (lsu_bus.req_rd | lsu_bus.req_wr);
   assign misalign = op_vld & lsu_misaligned(lsu_bus.req_size, off);
   assign pop      = lsu_bus.dmem_rsp_valid & ~fifo_empty;

   // A load may reuse the slot freed by a response arriving in the same cycle.
   assign issue  = op_vld & ~misalign & ~(lsu_bus.req_rd & fifo_full & ~pop);
   assign accept = issue & lsu_bus.dmem_req_ready;
   assign push   = accept & lsu_bus.req_rd;

   assign lsu_bus.misalign     = misalign;
   assign lsu_bus.stall        = op_vld & ~misalign & ~accept;
   assign lsu_bus.dmem_rd_en   = issue & lsu_bus.req_rd;
   assign lsu_bus.dmem_wr_en   = issue & lsu_bus.req_wr;
   assign lsu_bus.dmem_address = {lsu_bus.alu_out[ADDR_W-1:2], 2'b00};
   assign lsu_bus.dmem_byte_en = lsu_byte_en(lsu_bus.req_size, off);

   always_comb begin
      lsu_bus.dmem_wr_data = lsu_bus.wr_data;
      case (lsu_bus.req_size)
         LSU_BYTE: lsu_bus.dmem_wr_data = {4{lsu_bus.wr_data[7:0]}};
         LSU_HALF: lsu_bus.dmem_wr_data = {2{lsu_bus.wr_data[15:0]}};
         default:  lsu_bus.dmem_wr_data = lsu_bus.wr_data;
      endcase
   end

   assign push_meta.offset      = off;
   assign push_meta.size        = lsu_bus.req_size;
   assign push_meta.is_unsigned = lsu_bus.req_unsigned;

   mini_core_lsu_meta_fifo #(
      .DEPTH     (OUTSTANDING),
      .T_PAYLOAD (t_lsu_meta)
   ) u_meta_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (push_meta),
      .pop_i       (pop),
      .pop_data_o  (head_meta),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_cnt)
   );

   assign lsu_bus.outstanding_cnt = fifo_cnt;
   assign ext_data                = lsu_extend(lsu_bus.dmem_rsp_data, head_meta);

   generate
      if (REG_RSP) begin : g_reg_rsp
         logic        load_valid_q;
         logic        rsp_orphan_q;
         logic [31:0] load_data_q, load_data_d;

         assign load_data_d = pop ? ext_data : load_data_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               load_valid_q <= 1'b0;
               rsp_orphan_q <= 1'b0;
               load_data_q  <= '0;
            end else begin
               load_valid_q <= pop;
               rsp_orphan_q <= lsu_bus.dmem_rsp_valid & fifo_empty;
               load_data_q  <= load_data_d;
            end
         end

         assign lsu_bus.load_valid = load_valid_q;
         assign lsu_bus.load_data  = load_data_q;
         assign lsu_bus.rsp_orphan = rsp_orphan_q;
      end else begin : g_comb_rsp
         assign lsu_bus.load_valid = pop;
         assign lsu_bus.load_data  = ext_data;
         assign lsu_bus.rsp_orphan = lsu_bus.dmem_rsp_valid & fifo_empty;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_plus4_q <= '0;
         alu_out_q  <= '0;
      end else if (lsu_bus.ready_q104h) begin
         pc_plus4_q <= lsu_bus.pc_plus4;
         alu_out_q  <= lsu_bus.alu_out;
      end
   end

   assign lsu_bus.pc_plus4_q104h = pc_plus4_q;
   assign lsu_bus.alu_out_q104h  = alu_out_q;

endmodule

// File: tb/tb_mini_core_lsu_pipe.sv
// Directed bench for mini_core_lsu_pipe: one registered-response and one
// combinational-response instance fed from the same stimulus.
module tb_mini_core_lsu_pipe;
   import mini_core_lsu_pipe_pkg::*;

   localparam int ADDR_W      = 32;
   localparam int OUTSTANDING = 4;
   localparam int CNT_W       = 3;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   mini_core_lsu_pipe_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus_r ();
   mini_core_lsu_pipe_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus_c ();

   assign bus_c.req_valid      = bus_r.req_valid;
   assign bus_c.req_rd         = bus_r.req_rd;
   assign bus_c.req_wr         = bus_r.req_wr;
   assign bus_c.req_size       = bus_r.req_size;
   assign bus_c.req_unsigned   = bus_r.req_unsigned;
   assign bus_c.alu_out        = bus_r.alu_out;
   assign bus_c.wr_data        = bus_r.wr_data;
   assign bus_c.pc_plus4       = bus_r.pc_plus4;
   assign bus_c.ready_q104h    = bus_r.ready_q104h;
   assign bus_c.dmem_req_ready = bus_r.dmem_req_ready;
   assign bus_c.dmem_rsp_valid = bus_r.dmem_rsp_valid;
   assign bus_c.dmem_rsp_data  = bus_r.dmem_rsp_data;

   mini_core_lsu_pipe #(.ADDR_W(ADDR_W), .OUTSTANDING(OUTSTANDING), .REG_RSP(1'b1)) dut_r (
      .clk     (clk),
      .rst     (rst),
      .lsu_bus (bus_r.slave)
   );

   mini_core_lsu_pipe #(.ADDR_W(ADDR_W), .OUTSTANDING(OUTSTANDING), .REG_RSP(1'b0)) dut_c (
      .clk     (clk),
      .rst     (rst),
      .lsu_bus (bus_c.slave)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus_r.req_valid    = 1'b0;
      bus_r.req_rd       = 1'b0;
      bus_r.req_wr       = 1'b0;
      bus_r.req_size     = LSU_BYTE;
      bus_r.req_unsigned = 1'b0;
      bus_r.alu_out      = '0;
      bus_r.wr_data      = '0;
   endtask

   task automatic drive(input logic rd, input t_lsu_size sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] data);
      bus_r.req_valid    = 1'b1;
      bus_r.req_rd       = rd;
      bus_r.req_wr       = ~rd;
      bus_r.req_size     = sz;
      bus_r.req_unsigned = uns;
      bus_r.alu_out      = addr;
      bus_r.wr_data      = data;
   endtask

   // Lane-by-lane reference for the load result.
   function automatic logic [31:0] ref_load(input t_lsu_size sz, input logic uns,
                                            input logic [1:0] off, input logic [31:0] raw);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = raw[7:0];
         2'd1:    b = raw[15:8];
         2'd2:    b = raw[23:16];
         default: b = raw[31:24];
      endcase
      h = off[1] ? raw[31:16] : raw[15:0];
      case (sz)
         LSU_BYTE: return uns ? {24'h0, b} : {{24{b[7]}}, b};
         LSU_HALF: return uns ? {16'h0, h} : {{16{h[15]}}, h};
         default:  return raw;
      endcase
   endfunction

   // Issue one load, answer it on the following cycle, check both response styles.
   task automatic load_rt(input string name, input t_lsu_size sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] raw, input logic [31:0] exp);
      drive(1'b1, sz, uns, addr, 32'h0);
      #1;
      check({name, "_rd_en"}, 32'(bus_r.dmem_rd_en), 32'd1);
      check({name, "_stall"}, 32'(bus_r.stall), 32'd0);
      tick();
      check({name, "_cnt_after_issue"}, 32'(bus_r.outstanding_cnt), 32'd1);
      idle();
      bus_r.dmem_rsp_valid = 1'b1;
      bus_r.dmem_rsp_data  = raw;
      #1;
      check({name, "_comb_valid"}, 32'(bus_c.load_valid), 32'd1);
      check({name, "_comb_data"}, bus_c.load_data, exp);
      tick();
      bus_r.dmem_rsp_valid = 1'b0;
      check({name, "_reg_valid"}, 32'(bus_r.load_valid), 32'd1);
      check({name, "_reg_data"}, bus_r.load_data, exp);
      check({name, "_cnt_after_rsp"}, 32'(bus_r.outstanding_cnt), 32'd0);
      $display("txn load %s addr=0x%08h raw=0x%08h exp=0x%08h", name, addr, raw, exp);
   endtask

   initial begin
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  off;
      t_lsu_size   sz;
      logic        uns;

      rst = 1'b1;
      idle();
      bus_r.pc_plus4       = '0;
      bus_r.ready_q104h    = 1'b0;
      bus_r.dmem_req_ready = 1'b1;
      bus_r.dmem_rsp_valid = 1'b0;
      bus_r.dmem_rsp_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_cnt", 32'(bus_r.outstanding_cnt), 32'd0);
      check("rst_load_valid", 32'(bus_r.load_valid), 32'd0);
      check("rst_load_data", bus_r.load_data, 32'd0);
      check("rst_orphan", 32'(bus_r.rsp_orphan), 32'd0);
      check("rst_pc_q104h", bus_r.pc_plus4_q104h, 32'd0);
      check("rst_alu_q104h", bus_r.alu_out_q104h, 32'd0);
      rst = 1'b0;
      tick();

      // SB to 0x1003
      drive(1'b0, LSU_BYTE, 1'b0, 32'h0000_1003, 32'h0000_00AB);
      bus_r.ready_q104h = 1'b1;
      bus_r.pc_plus4    = 32'h0000_0104;
      #1;
      check("sb_byte_en", 32'(bus_r.dmem_byte_en), 32'h8);
      check("sb_wr_data", bus_r.dmem_wr_data, 32'hABAB_ABAB);
      check("sb_wr_en", 32'(bus_r.dmem_wr_en), 32'd1);
      check("sb_rd_en", 32'(bus_r.dmem_rd_en), 32'd0);
      check("sb_address", bus_r.dmem_address, 32'h0000_1000);
      check("sb_stall", 32'(bus_r.stall), 32'd0);
      tick();
      check("sb_cnt", 32'(bus_r.outstanding_cnt), 32'd0);
      check("sb_pc_q104h", bus_r.pc_plus4_q104h, 32'h0000_0104);
      check("sb_alu_q104h", bus_r.alu_out_q104h, 32'h0000_1003);
      $display("txn store sb addr=0x00001003 data=0x000000ab");
      idle();
      bus_r.ready_q104h = 1'b0;
      bus_r.pc_plus4    = 32'h0000_0200;
      tick();
      check("q104h_hold_pc", bus_r.pc_plus4_q104h, 32'h0000_0104);

      load_rt("lh",  LSU_HALF, 1'b0, 32'h0000_2002, 32'h8001_0000, 32'hFFFF_8001);
      load_rt("lhu", LSU_HALF, 1'b1, 32'h0000_2002, 32'h8001_0000, 32'h0000_8001);
      load_rt("lb",  LSU_BYTE, 1'b0, 32'h0000_2001, 32'h0000_9A00, 32'hFFFF_FF9A);
      load_rt("lbu", LSU_BYTE, 1'b1, 32'h0000_2003, 32'hF100_0000, 32'h0000_00F1);
      load_rt("lw",  LSU_WORD, 1'b0, 32'h0000_2000, 32'h1234_5678, 32'h1234_5678);

      // Misaligned word load
      drive(1'b1, LSU_WORD, 1'b0, 32'h0000_2001, 32'h0);
      #1;
      check("mis_flag", 32'(bus_r.misalign), 32'd1);
      check("mis_rd_en", 32'(bus_r.dmem_rd_en), 32'd0);
      check("mis_stall", 32'(bus_r.stall), 32'd0);
      tick();
      check("mis_cnt", 32'(bus_r.outstanding_cnt), 32'd0);
      $display("txn load misaligned lw addr=0x00002001");
      drive(1'b1, LSU_HALF, 1'b0, 32'h0000_2003, 32'h0);
      #1;
      check("mis_half_flag", 32'(bus_r.misalign), 32'd1);
      idle();
      tick();

      // Fill the queue with back-to-back loads
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, LSU_WORD, 1'b0, 32'h0000_3000 + 32'(4 * k), 32'h0);
         #1;
         check("fill_stall", 32'(bus_r.stall), 32'd0);
         tick();
         $display("txn load fill %0d addr=0x%08h", k, 32'h0000_3000 + 32'(4 * k));
      end
      check("fill_cnt", 32'(bus_r.outstanding_cnt), 32'd4);
      drive(1'b1, LSU_WORD, 1'b0, 32'h0000_3010, 32'h0);
      #1;
      check("full_stall", 32'(bus_r.stall), 32'd1);
      check("full_rd_en", 32'(bus_r.dmem_rd_en), 32'd0);
      tick();
      check("full_cnt_held", 32'(bus_r.outstanding_cnt), 32'd4);
      check("full_stall_held", 32'(bus_r.stall), 32'd1);
      bus_r.dmem_rsp_valid = 1'b1;
      bus_r.dmem_rsp_data  = 32'hCAFE_0001;
      #1;
      check("pushpop_stall", 32'(bus_r.stall), 32'd0);
      check("pushpop_rd_en", 32'(bus_r.dmem_rd_en), 32'd1);
      check("pushpop_comb_data", bus_c.load_data, 32'hCAFE_0001);
      tick();
      idle();
      bus_r.dmem_rsp_valid = 1'b0;
      check("pushpop_cnt", 32'(bus_r.outstanding_cnt), 32'd4);
      check("pushpop_reg_data", bus_r.load_data, 32'hCAFE_0001);
      $display("txn load fifth accepted with simultaneous response");
      for (int k = 0; k < 4; k++) begin
         bus_r.dmem_rsp_valid = 1'b1;
         bus_r.dmem_rsp_data  = 32'h5500_0000 + 32'(k);
         tick();
      end
      bus_r.dmem_rsp_valid = 1'b0;
      check("drain_cnt", 32'(bus_r.outstanding_cnt), 32'd0);
      check("drain_last_data", bus_r.load_data, 32'h5500_0003);
      tick();
      check("drain_valid_low", 32'(bus_r.load_valid), 32'd0);

      // Store under memory back-pressure
      bus_r.dmem_req_ready = 1'b0;
      drive(1'b0, LSU_WORD, 1'b0, 32'h0000_4000, 32'h1122_3344);
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_stall", 32'(bus_r.stall), 32'd1);
         check("bp_wr_en", 32'(bus_r.dmem_wr_en), 32'd1);
         check("bp_address", bus_r.dmem_address, 32'h0000_4000);
         check("bp_wr_data", bus_r.dmem_wr_data, 32'h1122_3344);
         tick();
      end
      bus_r.dmem_req_ready = 1'b1;
      #1;
      check("bp_accept_stall", 32'(bus_r.stall), 32'd0);
      tick();
      idle();
      check("bp_cnt", 32'(bus_r.outstanding_cnt), 32'd0);
      $display("txn store sw addr=0x00004000 after 3 stall cycles");

      // Reset with two loads in flight, then two late responses
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, LSU_WORD, 1'b0, 32'h0000_5000 + 32'(4 * k), 32'h0);
         tick();
      end
      idle();
      check("inflight_cnt", 32'(bus_r.outstanding_cnt), 32'd2);
      rst = 1'b1;
      #1;
      check("async_rst_cnt", 32'(bus_r.outstanding_cnt), 32'd0);
      check("async_rst_pc", bus_r.pc_plus4_q104h, 32'd0);
      #1;
      rst = 1'b0;
      tick();
      for (int k = 0; k < 2; k++) begin
         bus_r.dmem_rsp_valid = 1'b1;
         bus_r.dmem_rsp_data  = 32'hDEAD_0000 + 32'(k);
         #1;
         check("orphan_comb", 32'(bus_c.rsp_orphan), 32'd1);
         check("orphan_comb_valid", 32'(bus_c.load_valid), 32'd0);
         tick();
         check("orphan_reg", 32'(bus_r.rsp_orphan), 32'd1);
         check("orphan_reg_valid", 32'(bus_r.load_valid), 32'd0);
         check("orphan_cnt", 32'(bus_r.outstanding_cnt), 32'd0);
         $display("txn orphan response %0d", k);
      end
      bus_r.dmem_rsp_valid = 1'b0;
      tick();
      check("orphan_end", 32'(bus_r.rsp_orphan), 32'd0);

      // Random aligned loads/stores against the reference
      for (int n = 0; n < 24; n++) begin
         sz   = t_lsu_size'($urandom_range(0, 2));
         uns  = 1'($urandom_range(0, 1));
         off  = 2'($urandom_range(0, 3));
         if (sz == LSU_HALF) off[0] = 1'b0;
         if (sz == LSU_WORD) off = 2'b00;
         addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} | 32'(off);
         data = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            case (sz)
               LSU_BYTE: begin
                  exp_wd = {data[7:0], data[7:0], data[7:0], data[7:0]};
                  case (off)
                     2'd0:    exp_be = 4'b0001;
                     2'd1:    exp_be = 4'b0010;
                     2'd2:    exp_be = 4'b0100;
                     default: exp_be = 4'b1000;
                  endcase
               end
               LSU_HALF: begin
                  exp_wd = {data[15:0], data[15:0]};
                  exp_be = off[1] ? 4'b1100 : 4'b0011;
               end
               default: begin
                  exp_wd = data;
                  exp_be = 4'b1111;
               end
            endcase
            drive(1'b0, sz, uns, addr, data);
            #1;
            check("rnd_st_be", 32'(bus_r.dmem_byte_en), 32'(exp_be));
            check("rnd_st_wd", bus_r.dmem_wr_data, exp_wd);
            check("rnd_st_addr", bus_r.dmem_address, {addr[31:2], 2'b00});
            tick();
            idle();
            $display("txn store rnd addr=0x%08h data=0x%08h size=%0d", addr, data, sz);
         end else begin
            load_rt("rnd_ld", sz, uns, addr, data, ref_load(sz, uns, off, data));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
